sdram_client_arbiter: RTL and testbench

// - Shares the single sdram_controller user port between two independent clients (c0, c1).
// - Each client issues single 128-bit read or write transactions.
// - Round-robin arbitration; one transaction in flight at a time.
// - Sits between client logic and sdram_controller:
//   - drives its iwrite_*/iread_* inputs;
//   - consumes its owrite_ack, oread_ack, oread_data and oinit_done.

---
 rtl/sdram_client_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sdram_client_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_client_arbiter.sv
// Two-client round-robin arbiter in front of the sdram_controller user port.
// One 128-bit read or write is in flight at a time, with a WAIT timeout that aborts the transaction with an error.
//
// state | meaning
// IDLE  | controller not initialised, no grants
// ARB   | pick a requester (round-robin), latch its request
// ISSUE | one-cycle write/read request pulse to controller
// WAIT  | wait for the matching controller ack or timeout
// RESP  | one-cycle ack/err pulse to the granted client
module sdram_client_arbiter #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 4095
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              ic0_req,
    input  logic              ic0_we,
    input  logic [ADDR_W-1:0] ic0_addr,
    input  logic [DATA_W-1:0] ic0_wdata,
    output logic              oc0_ack,
    output logic              oc0_err,
    output logic [DATA_W-1:0] oc0_rdata,
    input  logic              ic1_req,
    input  logic              ic1_we,
    input  logic [ADDR_W-1:0] ic1_addr,
    input  logic [DATA_W-1:0] ic1_wdata,
    output logic              oc1_ack,
    output logic              oc1_err,
    output logic [DATA_W-1:0] oc1_rdata,
    input  logic              iinit_done,
    output logic              owrite_req,
    output logic [ADDR_W-1:0] owrite_address,
    output logic [DATA_W-1:0] owrite_data,
    input  logic              iwrite_ack,
    output logic              oread_req,
    output logic [ADDR_W-1:0] oread_address,
    input  logic [DATA_W-1:0] iread_data,
    input  logic              iread_ack,
    output logic              obusy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // Down-counter loaded with TIMEOUT-1 so terminal count 0 falls on the TIMEOUT-th WAIT cycle.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit TO_EN = (TIMEOUT != 0);

    state_t             state;
    logic               ptr;
    logic               gnt;
    logic               lat_we;
    logic [CNT_W-1:0]   cnt;

    logic               pick_c1;
    logic               any_req;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               wait_done;
    logic               wait_to;

    assign any_req   = ic0_req | ic1_req;
    assign pick_c1   = ic1_req & (~ic0_req | ptr);
    assign sel_we    = pick_c1 ? ic1_we    : ic0_we;
    assign sel_addr  = pick_c1 ? ic1_addr  : ic0_addr;
    assign sel_wdata = pick_c1 ? ic1_wdata : ic0_wdata;
    assign wait_done = lat_we ? iwrite_ack : iread_ack;
    assign wait_to   = TO_EN && (cnt == '0);

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state          <= S_IDLE;
            ptr            <= 1'b0;
            gnt            <= 1'b0;
            lat_we         <= 1'b0;
            cnt            <= '0;
            oc0_ack        <= 1'b0;
            oc0_err        <= 1'b0;
            oc0_rdata      <= '0;
            oc1_ack        <= 1'b0;
            oc1_err        <= 1'b0;
            oc1_rdata      <= '0;
            owrite_req     <= 1'b0;
            owrite_address <= '0;
            owrite_data    <= '0;
            oread_req      <= 1'b0;
            oread_address  <= '0;
            obusy          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iinit_done)
                        state <= S_ARB;
                end
                S_ARB: begin
                    if (!iinit_done) begin
                        state <= S_IDLE;
                    end else if (!(iwrite_ack | iread_ack) && any_req) begin
                        gnt    <= pick_c1;
                        lat_we <= sel_we;
                        obusy  <= 1'b1;
                        if (sel_we) begin
                            owrite_req     <= 1'b1;
                            owrite_address <= sel_addr;
                            owrite_data    <= sel_wdata;
                        end else begin
                            oread_req     <= 1'b1;
                            oread_address <= sel_addr;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    owrite_req <= 1'b0;
                    oread_req  <= 1'b0;
                    cnt        <= TO_LOAD;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_done || wait_to) begin
                        // A real ack beats a timeout landing in the same cycle.
                        if (gnt) begin
                            oc1_ack <= 1'b1;
                            oc1_err <= ~wait_done;
                            if (wait_done && !lat_we)
                                oc1_rdata <= iread_data;
                        end else begin
                            oc0_ack <= 1'b1;
                            oc0_err <= ~wait_done;
                            if (wait_done && !lat_we)
                                oc0_rdata <= iread_data;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    oc0_ack <= 1'b0;
                    oc0_err <= 1'b0;
                    oc1_ack <= 1'b0;
                    oc1_err <= 1'b0;
                    ptr     <= ~gnt;
                    obusy   <= 1'b0;
                    state   <= S_ARB;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Directed bench for sdram_client_arbiter with a behavioural controller/memory model.
// Client transactions come from a vector table; latency, fairness, timeout and reset use hand sequences.
module tb_sdram_client_arbiter;
    localparam int AW = 22;
    localparam int DW = 128;
    localparam int TO = 16;

    logic          iclk = 1'b0;
    logic          ireset;
    logic          ic0_req, ic0_we, ic1_req, ic1_we;
    logic [AW-1:0] ic0_addr, ic1_addr;
    logic [DW-1:0] ic0_wdata, ic1_wdata;
    logic          oc0_ack, oc0_err, oc1_ack, oc1_err;
    logic [DW-1:0] oc0_rdata, oc1_rdata;
    logic          iinit_done;
    logic          owrite_req, oread_req, iwrite_ack, iread_ack, obusy;
    logic [AW-1:0] owrite_address, oread_address;
    logic [DW-1:0] owrite_data, iread_data;

    int total = 0;
    int bad = 0;

    always #5 iclk = ~iclk;

    sdram_client_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .iclk(iclk), .ireset(ireset),
        .ic0_req(ic0_req), .ic0_we(ic0_we), .ic0_addr(ic0_addr), .ic0_wdata(ic0_wdata),
        .oc0_ack(oc0_ack), .oc0_err(oc0_err), .oc0_rdata(oc0_rdata),
        .ic1_req(ic1_req), .ic1_we(ic1_we), .ic1_addr(ic1_addr), .ic1_wdata(ic1_wdata),
        .oc1_ack(oc1_ack), .oc1_err(oc1_err), .oc1_rdata(oc1_rdata),
        .iinit_done(iinit_done),
        .owrite_req(owrite_req), .owrite_address(owrite_address), .owrite_data(owrite_data),
        .iwrite_ack(iwrite_ack),
        .oread_req(oread_req), .oread_address(oread_address),
        .iread_data(iread_data), .iread_ack(iread_ack),
        .obusy(obusy)
    );

    // Controller model: acks 'lat' cycles after the request pulse unless 'dead'.
    bit            dead = 1'b0;
    int            lat = 0;
    bit            pend = 1'b0;
    bit            pend_we = 1'b0;
    int            mcnt = 0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] mem [logic [AW-1:0]];

    initial begin
        iwrite_ack = 1'b0;
        iread_ack  = 1'b0;
        iread_data = '0;
    end

    always @(negedge iclk) begin
        iwrite_ack = 1'b0;
        iread_ack  = 1'b0;
        if (pend && !dead) begin
            if (mcnt == 0) begin
                if (pend_we) begin
                    iwrite_ack = 1'b1;
                end else begin
                    iread_ack  = 1'b1;
                    iread_data = mem.exists(paddr) ? mem[paddr] : '0;
                end
                pend = 1'b0;
            end else begin
                mcnt--;
            end
        end
        if (owrite_req) begin
            mem[owrite_address] = owrite_data;
            pend = 1'b1; pend_we = 1'b1; mcnt = lat;
        end
        if (oread_req) begin
            paddr = oread_address;
            pend = 1'b1; pend_we = 1'b0; mcnt = lat;
        end
    end

    typedef struct {
        int            c;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t          vecs [9];
    logic [DW-1:0] exp_rd [2];
    int            exp_ptr;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int c, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (c == 0) begin
            ic0_req = req; ic0_we = we; ic0_addr = addr; ic0_wdata = wdata;
        end else begin
            ic1_req = req; ic1_we = we; ic1_addr = addr; ic1_wdata = wdata;
        end
    endtask

    // who: 0 or 1 for the acked client, 2 if both acked at once, -1 on expiry.
    task automatic wait_ack(output int who);
        who = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge iclk);
            if (oc0_ack && oc1_ack) begin who = 2; return; end
            if (oc0_ack) begin who = 0; return; end
            if (oc1_ack) begin who = 1; return; end
        end
    endtask

    task automatic txn(input int c, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
        int who;
        drive(c, 1'b1, we, addr, wdata);
        wait_ack(who);
        chk($sformatf("ack_client c%0d", c), DW'(who), DW'(c));
        chk($sformatf("ack_err c%0d", c), DW'(c == 0 ? oc0_err : oc1_err), '0);
        if (!we) exp_rd[c] = exp_rdata;
        chk("rdata_c0", oc0_rdata, exp_rd[0]);
        chk("rdata_c1", oc1_rdata, exp_rd[1]);
        drive(c, 1'b0, 1'b0, '0, '0);
        exp_ptr = 1 - c;
    endtask

    initial begin
        int who, pulses, acks, n, exp_c;
        logic [DW-1:0] d0, d1;
        d0 = 128'hDEADBEEFCAFEBABE123456789ABCDEF0;
        d1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
        vecs[0] = '{0, 1'b1, 22'h000001, d0, '0};
        vecs[1] = '{0, 1'b0, 22'h000001, '0, d0};
        vecs[2] = '{0, 1'b1, 22'h000002, {32{4'hA}}, '0};
        vecs[3] = '{1, 1'b0, 22'h000002, '0, {32{4'hA}}};
        vecs[4] = '{1, 1'b1, 22'h000003, {32{4'h5}}, '0};
        vecs[5] = '{0, 1'b0, 22'h000003, '0, {32{4'h5}}};
        vecs[6] = '{1, 1'b0, 22'h000001, '0, d0};
        vecs[7] = '{0, 1'b1, 22'h000001, d1, '0};
        vecs[8] = '{1, 1'b0, 22'h000001, '0, d1};
        exp_rd[0] = '0; exp_rd[1] = '0; exp_ptr = 0;

        ireset = 1'b1; iinit_done = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge iclk);
        chk("reset_outputs", DW'({owrite_req, oread_req, obusy, oc0_ack, oc1_ack, oc0_err, oc1_err}), '0);
        chk("reset_rdata", oc0_rdata | oc1_rdata, '0);
        ireset = 1'b0;

        // Request while controller not initialised: nothing issued until iinit_done.
        drive(0, 1'b1, 1'b1, 22'h3FFFFF, 128'h1);
        pulses = 0;
        repeat (10) begin
            @(negedge iclk);
            if (owrite_req || oread_req || obusy) pulses++;
        end
        chk("no_req_before_init", DW'(pulses), '0);
        iinit_done = 1'b1;
        acks = 0;
        repeat (20) begin
            @(negedge iclk);
            if (owrite_req || oread_req) pulses++;
            if (oc0_ack) begin acks++; drive(0, 1'b0, 1'b0, '0, '0); end
        end
        chk("one_req_after_init", DW'(pulses), DW'(1));
        chk("one_ack_after_init", DW'(acks), DW'(1));
        exp_ptr = 1;

        lat = 1;
        for (int i = 0; i < 9; i++)
            txn(vecs[i].c, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // Latency with idle arbiter and immediate controller ack.
        lat = 0;
        @(negedge iclk);
        drive(1, 1'b1, 1'b0, 22'h000002, '0);
        @(negedge iclk);
        chk("issue_cycle2", DW'(oread_req), DW'(1));
        chk("issue_addr", DW'(oread_address), DW'(22'h000002));
        @(negedge iclk);
        chk("no_ack_in_wait", DW'(oc1_ack), '0);
        @(negedge iclk);
        chk("ack_after_wait", DW'(oc1_ack), DW'(1));
        chk("ack_rdata", oc1_rdata, {32{4'hA}});
        exp_rd[1] = {32{4'hA}};
        drive(1, 1'b0, 1'b0, '0, '0);
        exp_ptr = 0;

        // Both clients request continuously: grants alternate.
        lat = 2;
        @(negedge iclk);
        drive(0, 1'b1, 1'b1, 22'h000010, 128'h10);
        drive(1, 1'b1, 1'b1, 22'h000011, 128'h11);
        exp_c = exp_ptr;
        for (int k = 0; k < 8; k++) begin
            wait_ack(who);
            chk($sformatf("alternate_%0d", k), DW'(who), DW'(exp_c));
            exp_c = 1 - exp_c;
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        exp_ptr = exp_c;
        chk("alt_rdata_c0", oc0_rdata, exp_rd[0]);

        // Controller never acks: error ack exactly TO cycles after WAIT entry.
        dead = 1'b1;
        @(negedge iclk);
        drive(0, 1'b1, 1'b0, 22'h000001, '0);
        n = 0;
        while (!oread_req && n < 20) begin @(negedge iclk); n++; end
        chk("timeout_issue_seen", DW'(oread_req), DW'(1));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge iclk);
            n++;
            if (oc0_ack || oc1_ack) break;
        end
        chk("timeout_cycles", DW'(n), DW'(TO + 1));
        chk("timeout_ack_c0", DW'({oc0_ack, oc1_ack}), DW'(2'b10));
        chk("timeout_err", DW'(oc0_err), DW'(1));
        chk("timeout_rdata_kept", oc0_rdata, exp_rd[0]);
        drive(0, 1'b0, 1'b0, '0, '0);
        exp_ptr = 1;
        @(posedge iclk); #1 pend = 1'b0; dead = 1'b0;
        @(negedge iclk);
        txn(1, 1'b1, 22'h000004, 128'h44, '0);

        // Reset in WAIT: outputs clear at once, no late ack, pointer back to c0.
        txn(0, 1'b1, 22'h000005, 128'h55, '0);
        dead = 1'b1;
        drive(0, 1'b1, 1'b0, 22'h000005, '0);
        n = 0;
        while (!oread_req && n < 20) begin @(negedge iclk); n++; end
        @(negedge iclk);
        chk("busy_in_wait", DW'(obusy), DW'(1));
        #1 ireset = 1'b1;
        #1;
        chk("rst_ctrl_outputs", DW'({owrite_req, oread_req, obusy, oc0_ack, oc1_ack, oc0_err, oc1_err}), '0);
        chk("rst_addr_data", DW'(owrite_address) | DW'(oread_address) | owrite_data, '0);
        chk("rst_rdata", oc0_rdata | oc1_rdata, '0);
        exp_rd[0] = '0; exp_rd[1] = '0;
        @(posedge iclk); #1 pend = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge iclk);
        ireset = 1'b0; dead = 1'b0;
        acks = 0;
        repeat (20) begin
            @(negedge iclk);
            if (oc0_ack || oc1_ack) acks++;
        end
        chk("no_ack_after_reset", DW'(acks), '0);
        drive(0, 1'b1, 1'b1, 22'h000006, 128'h66);
        drive(1, 1'b1, 1'b1, 22'h000007, 128'h77);
        wait_ack(who);
        chk("ptr_c0_after_reset", DW'(who), '0);
        drive(0, 1'b0, 1'b0, '0, '0);
        wait_ack(who);
        chk("c1_after_c0", DW'(who), DW'(1));
        drive(1, 1'b0, 1'b0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
